// File: rtl/riscv_lsu.sv
// RV32I load-store unit: turns core byte/half/word accesses into word-aligned
// memory transactions and formats returned load data for writeback.
module riscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        size_q;
  logic [1:0]        off_q;
  logic              we_q;
  logic [XLEN-1:0]   rd_q;
  logic              misaligned_c;
  logic              accept_c;
  logic              load_done_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [XLEN-1:0]   load_fmt_c;

  // Size is decoded on the low two funct3 bits: 0=byte, 1=half, else word.
  always_comb begin
    misaligned_c = 1'b0;
    case (core_size_i[1:0])
      2'd0:    misaligned_c = 1'b0;
      2'd1:    misaligned_c = core_addr_i[0];
      default: misaligned_c = (core_addr_i[1:0] != 2'b00);
    endcase
  end

  // Next state and memory/core handshake; reset masks every strobe.
  always_comb begin
    state_d      = state_q;
    accept_c     = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    core_stall_o = 1'b0;
    misalign_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          if (misaligned_c) begin
            misalign_o = 1'b1;
          end else begin
            accept_c     = 1'b1;
            mem_req_o    = 1'b1;
            mem_we_o     = core_we_i;
            core_stall_o = 1'b1;
            state_d      = WAIT;
          end
        end
      end
      WAIT: begin
        core_stall_o = ~mem_ready_i;
        if (mem_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      accept_c     = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      core_stall_o = 1'b0;
      misalign_o   = 1'b0;
    end
  end

  // Store lane placement and replication.
  always_comb begin
    mem_addr_o = {core_addr_i[31:2], 2'b00};
    mem_be_o   = 4'b1111;
    mem_wd_o   = core_wd_i;
    case (core_size_i[1:0])
      2'd0: begin
        mem_wd_o = {4{core_wd_i[7:0]}};
        if (core_we_i) mem_be_o = 4'b0001 << core_addr_i[1:0];
      end
      2'd1: begin
        mem_wd_o = {2{core_wd_i[15:0]}};
        if (core_we_i) mem_be_o = 4'b0011 << core_addr_i[1:0];
      end
      default: begin
        mem_wd_o = core_wd_i;
        mem_be_o = 4'b1111;
      end
    endcase
  end

  // Load extraction using the offset/size captured at issue.
  always_comb begin
    byte_c = 8'h00;
    case (off_q)
      2'd0: byte_c = mem_rd_i[7:0];
      2'd1: byte_c = mem_rd_i[15:8];
      2'd2: byte_c = mem_rd_i[23:16];
      2'd3: byte_c = mem_rd_i[31:24];
      default: byte_c = 8'h00;
    endcase
    half_c = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_q[1:0])
      2'd0:    load_fmt_c = size_q[2] ? {24'h000000, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'd1:    load_fmt_c = size_q[2] ? {16'h0000, half_c} : {{16{half_c[15]}}, half_c};
      default: load_fmt_c = mem_rd_i;
    endcase
  end

  assign load_done_c = (state_q == WAIT) && mem_ready_i && !we_q && !rst_i;
  assign core_rd_o   = load_done_c ? load_fmt_c : rd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        size_q <= core_size_i;
        off_q  <= core_addr_i[1:0];
        we_q   <= core_we_i;
      end
      if (load_done_c) rd_q <= load_fmt_c;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed and randomized checks of riscv_lsu against an arithmetic model of
// RV32I access sizing, lane placement and load extension.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd;
  logic [31:0] core_rd;
  logic        core_stall, misalign;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd_model = 32'h0;

  always #5 clk = ~clk;

  riscv_lsu dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(core_rd), .core_stall_o(core_stall), .misalign_o(misalign),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
    .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] size);
    if (size == 3'd0 || size == 3'd4) return 1;
    if (size == 3'd1 || size == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [2:0] size, input logic [31:0] addr);
    int n;
    int mask;
    n = nbytes(size);
    if (!we || n == 4) return 4'hF;
    mask = ((1 << n) - 1) << (addr % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] size, input logic [31:0] wd);
    int n;
    n = nbytes(size);
    if (n == 1) return (wd % 256) * 32'h01010101;
    if (n == 2) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] word);
    int n;
    logic [31:0] v;
    n = nbytes(size);
    if (n == 4) return word;
    v = word >> (8 * (addr % 4));
    if (n == 1) begin
      v = v % 256;
      if (size == 3'd0 && v >= 128) v = v - 256;
    end else begin
      v = v % 65536;
      if (size == 3'd1 && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  // One complete core access; returns in the IDLE cycle after completion.
  task automatic access(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int lat);
    logic [31:0] exp;
    bit mis;
    core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
    mem_ready = 1'b0; mem_rd = 32'hDEAD_0000;
    #1;
    mis = (addr % nbytes(size)) != 0;
    chk({tag, ".misalign"}, 32'(misalign), 32'(mis));
    chk({tag, ".req"}, 32'(mem_req), 32'(!mis));
    chk({tag, ".stall"}, 32'(core_stall), 32'(!mis));
    if (mis) begin
      chk({tag, ".rd_hold"}, core_rd, rd_model);
      cyc();
      core_req = 1'b0;
      return;
    end
    chk({tag, ".we"}, 32'(mem_we), 32'(we));
    chk({tag, ".addr"}, mem_addr, addr & 32'hFFFF_FFFC);
    chk({tag, ".be"}, 32'(mem_be), 32'(exp_be(we, size, addr)));
    if (we) chk({tag, ".wd"}, mem_wd, exp_wd(size, wd));
    cyc();
    for (int i = 0; i < lat; i++) begin
      #1;
      chk({tag, ".wait_stall"}, 32'(core_stall), 32'd1);
      chk({tag, ".wait_req"}, 32'(mem_req), 32'd0);
      cyc();
    end
    mem_ready = 1'b1; mem_rd = rdata;
    #1;
    chk({tag, ".ready_stall"}, 32'(core_stall), 32'd0);
    chk({tag, ".ready_req"}, 32'(mem_req), 32'd0);
    if (!we) rd_model = exp_load(size, addr, rdata);
    chk({tag, ".rd"}, core_rd, rd_model);
    cyc();
    mem_ready = 1'b0; core_req = 1'b0;
  endtask

  initial begin
    logic [2:0] sizes [5];
    sizes[0] = 3'd0; sizes[1] = 3'd1; sizes[2] = 3'd2; sizes[3] = 3'd4; sizes[4] = 3'd5;
    rst = 1'b1; core_req = 1'b1; core_we = 1'b0; core_size = 3'd2;
    core_addr = 32'h0000_1000; core_wd = 32'h0; mem_rd = 32'h0; mem_ready = 1'b0;

    // Reset with an aligned request presented, then a misaligned one.
    cyc(); cyc();
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.stall", 32'(core_stall), 32'd0);
    chk("rst.rd", core_rd, 32'd0);
    core_addr = 32'h0000_1001; #1;
    chk("rst.misalign", 32'(misalign), 32'd0);
    cyc();
    rst = 1'b0; core_req = 1'b0; mem_ready = 1'b1; #1;
    chk("idle.ready_ignored_stall", 32'(core_stall), 32'd0);
    chk("idle.ready_ignored_rd", core_rd, 32'd0);
    cyc();

    access("sb", 1'b1, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0);
    chk("sb.be_const", 32'(exp_be(1'b1, 3'd0, 32'h1003)), 32'h8);
    access("lb", 1'b0, 3'd0, 32'h0000_2002, 32'h0, 32'h12F4_5678, 0);
    chk("lb.value", rd_model, 32'hFFFF_FFF4);
    access("lbu", 1'b0, 3'd4, 32'h0000_2002, 32'h0, 32'h12F4_5678, 1);
    chk("lbu.value", rd_model, 32'h0000_00F4);
    access("lh", 1'b0, 3'd1, 32'h0000_2002, 32'h0, 32'h12F4_5678, 0);
    chk("lh.value", rd_model, 32'h0000_12F4);
    access("lw_mis", 1'b0, 3'd2, 32'h0000_3001, 32'h0, 32'h0, 0);
    access("sh_mis", 1'b1, 3'd1, 32'h0000_3003, 32'h1234, 32'h0, 0);
    access("lh_ok", 1'b0, 3'd1, 32'h0000_3002, 32'h0, 32'h8001_0000, 0);
    access("lw_lat", 1'b0, 3'd2, 32'h0000_4000, 32'h0, 32'hCAFE_BABE, 3);
    #1;
    chk("lw_lat.held", core_rd, 32'hCAFE_BABE);
    cyc();

    // Back-to-back: second request presented in the cycle right after ready.
    access("b2b_sw", 1'b1, 3'd2, 32'h0000_5004, 32'h0102_0304, 32'h0, 0);
    access("b2b_lw", 1'b0, 3'd2, 32'h0000_5004, 32'h0, 32'h0102_0304, 0);

    // Reset while waiting abandons the load and clears the result.
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h0000_6000;
    cyc();
    rst = 1'b1; #1;
    chk("rstw.req", 32'(mem_req), 32'd0);
    chk("rstw.stall", 32'(core_stall), 32'd0);
    cyc();
    rst = 1'b0; core_req = 1'b0; mem_ready = 1'b1; mem_rd = 32'h7777_7777; #1;
    rd_model = 32'h0;
    chk("rstw.late_ready_stall", 32'(core_stall), 32'd0);
    chk("rstw.late_ready_rd", core_rd, 32'd0);
    cyc();
    mem_ready = 1'b0;
    access("post_rst", 1'b0, 3'd5, 32'h0000_6002, 32'h0, 32'h9ABC_0000, 0);

    // Randomized accesses with idle gaps and variable latency.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  sz;
      logic [31:0] ad, wd, rdw;
      sz  = sizes[$urandom_range(0, 4)];
      ad  = $urandom;
      wd  = $urandom;
      rdw = $urandom;
      access("rnd", 1'($urandom_range(0, 1)), sz, ad, wd, rdw, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        mem_ready = 1'($urandom_range(0, 1)); #1;
        chk("rnd.idle_stall", 32'(core_stall), 32'd0);
        chk("rnd.idle_rd", core_rd, rd_model);
        cyc();
        mem_ready = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
